seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle integer divider for the MIPS datapath. Serves DIV and DIVU, and writes the HI/LO pair (LO = quotient, HI = remainder).
- Performs the inverse of the adder chain: restoring division, one shift-and-subtract step per clock, using a borrow-chain subtract stage.
- Sits beside the ALU. The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request a division; sampled only in IDLE
- is_signed  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  high from the cycle after start acceptance until done deasserts
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient; held until next accepted start
- remainder  output  WIDTH  registered remainder; held until next accepted start
- div_by_zero  output  1  registered; set with done when the captured divisor == 0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Any in-flight operation is abandoned.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Capture operands.
  - For signed operands, store magnitudes (abs via negate), sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Partial remainder = 0, count = 0, go to RUN.
  - At this edge busy goes high, and quotient, remainder and div_by_zero are cleared to 0.
- RUN:
  - Each edge: shift {rem, quo} left by 1.
  - Trial subtract: rem_shifted - |divisor|. If no borrow, rem = difference and the quo LSB = 1; otherwise restore and LSB = 0.
  - count increments. After WIDTH iterations (edges E1..E_WIDTH) go to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction: negate quo if sign_q, negate rem if sign_r.
  - Divisor == 0 overrides: quotient = all ones, remainder = original dividend, div_by_zero = 1.
  - Register the outputs, set done = 1, go to DONE.
- DONE: done is high for exactly this one cycle. Next edge: done = 0, busy = 0, go to IDLE.
- Latency:
  - Fixed: done is high in the cycle following edge E_WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
  - Divide-by-zero does not shorten latency.
- start while busy (RUN/FIX/DONE): ignored, no queuing. start in the same cycle done is high is also ignored. The earliest new acceptance is the first IDLE cycle.
- Signed overflow (min_int / -1): the magnitude of min_int is 2^(WIDTH-1) unsigned, so quotient = min_int and remainder = 0. No trap, no flag.
- Arithmetic:
  - Magnitudes are treated as unsigned WIDTH bits.
  - The trial subtract is WIDTH+1 bits wide so the borrow-out is explicit.
  - Remainder magnitude is always < |divisor| when divisor != 0.
- Operand inputs may change freely after acceptance. Only captured copies are used.

Decomposition:
- Shared include (div_defs.vh): state encodings IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3; counter width = clog2(WIDTH)+1.
- One sub-module, restore_step:
  - Purely combinational, WIDTH+1-bit borrow-chain subtractor.
  - Inputs: shifted partial remainder, divisor magnitude.
  - Outputs: next remainder and quotient bit, where q_bit = NOT borrow_out.
  - Built as a borrow-propagate chain (the subtractive counterpart of the carry chain). Instantiated once; the FSM and registers live in seq_divider.

Test Plan:
- Unsigned: dividend=100, divisor=7, is_signed=0 → done exactly 33 cycles after accept; quotient=14, remainder=2, div_by_zero=0; busy high for 34 cycles.
- Signed: dividend=0xFFFFFFF9 (-7), divisor=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: dividend=5, divisor=0, unsigned and signed → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done still at cycle 33.
- Overflow/extremes: 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0. 0xFFFFFFFF / 1 unsigned → quotient=0xFFFFFFFF, remainder=0.
- Reset mid-operation: accept 100/7, assert rst at cycle 10 (asynchronously, between edges) → busy, done, quotient, remainder all 0 immediately. After release, a fresh 9/3 gives quotient=3, remainder=0.
- Start while busy: accept 100/7, pulse start with 50/5 at cycles 5 and 34 (done cycle) → only 14/2 produced, with a single done pulse. A start in the following IDLE cycle is accepted and yields 10/0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int count_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_restore_step.sv
// rtl/seq_divider_restore_step.sv - one restoring-division step built on a borrow-propagate chain
module restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  always_comb begin
    logic b;
    b    = 1'b0;
    diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = rem_shift[i] ^ dvs_mag[i] ^ b;
      b       = (~rem_shift[i] & dvs_mag[i]) | (~(rem_shift[i] ^ dvs_mag[i]) & b);
    end
    // Top stage subtracts a zero divisor bit; a set top bit absorbs any borrow.
    borrow_out = ~rem_shift[WIDTH] & b;
  end

  assign q_bit    = ~borrow_out;
  assign rem_next = q_bit ? diff : rem_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider (DIV/DIVU) producing quotient and remainder
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_bits(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dividend_q;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // min_int negates to itself, which is exactly its unsigned magnitude.
  assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_shift(({rem, quo[WIDTH-1]})),
    .dvs_mag  (dvs_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      dividend_q  <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_q  <= dividend;
            quo         <= dividend_mag;
            dvs_mag     <= divisor_mag;
            sign_q      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r      <= is_signed & dividend[WIDTH-1];
            rem         <= '0;
            count       <= '0;
            busy        <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          rem   <= rem_next;
          quo   <= {quo[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor magnitude only arises from a zero divisor.
          if (dvs_mag == '0) begin
            quotient    <= '1;
            remainder   <= dividend_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? -quo : quo;
            remainder   <= sign_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating toward zero for signed.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("idle_before_start", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    logic        ez;
    int          lat, busy_n;
    ref_div(a, b, s, eq, er, ez);
    wait_idle();
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~s;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    check({tag, "_q_cleared"}, quotient, 32'd0);
    check({tag, "_dbz_cleared"}, 32'(div_by_zero), 32'd0);
    lat    = 0;
    busy_n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    if (busy) busy_n++;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd34);
    check({tag, "_q_held"}, quotient, eq);
  endtask

  initial begin
    logic [31:0] ra, rb, q1, r1, q2, r2;
    logic        rs;
    int          ndone, d1, d2, sel;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("u_100_7", 32'd100, 32'd7, 1'b0);
    do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    do_op("u_div0", 32'd5, 32'd0, 1'b0);
    do_op("s_div0", 32'd5, 32'd0, 1'b1);
    do_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("s_m8_div0", 32'hFFFF_FFF8, 32'd0, 1'b1);
    do_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Asynchronous reset in the low phase of the clock, mid-operation.
    wait_idle();
    dividend = 32'd100;
    divisor  = 32'd7;
    is_signed = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst_9_3", 32'd9, 32'd3, 1'b0);

    // Starts while busy and during done are dropped; first IDLE start is taken.
    wait_idle();
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = k; q1 = quotient; r1 = remainder;
        end else begin
          d2 = k; q2 = quotient; r2 = remainder;
        end
      end
      if (k == 34) check("busy_low_in_idle", 32'(busy), 32'd0);
      if (k == 35) check("idle_start_accepted", 32'(busy), 32'd1);
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = (k == 4) || (k == 33) || (k == 34);
    end
    check("ignore_first_done_cycle", 32'(d1), 32'd33);
    check("ignore_quotient", q1, 32'd14);
    check("ignore_remainder", r1, 32'd2);
    check("second_done_cycle", 32'(d2), 32'd68);
    check("second_quotient", q2, 32'd10);
    check("second_remainder", r2, 32'd0);
    check("done_pulse_count", 32'(ndone), 32'd2);

    for (int n = 0; n < 30; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) ra = 32'($urandom_range(0, 100));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      do_op("rand", ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
